hazard_scoreboard: RTL

Parametrised hazard and forwarding controller for the pipelined MIPS core. It replaces the fixed-depth stall and forwarding logic with a per-register scoreboard. For each tracked register it holds a busy bit, a result-latency countdown and a pipeline-age counter. From that state it decides decode-stage stalls and per-operand forward-source selectors for any pipeline depth and any mix of result latencies (ALU, load, multi-cycle ops).

---
 rtl/hazard_scoreboard.sv | 127 ++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
//------------------------------------------------------------------------------
// Module   : hazard_scoreboard
// Purpose  : Per-register scoreboard that decides decode stalls and operand
//            forward-source selectors. Forwarding is enabled by defining
//            HAZARD_SB_FORWARD_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hazard_scoreboard #(
    parameter  int NREG   = 32,
    parameter  int DEPTH  = 4,
    parameter  int MAXLAT = 3,
    localparam int RW     = $clog2(NREG),
    localparam int AGW    = $clog2(DEPTH + 1),
    localparam int LW     = $clog2(MAXLAT + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           issue_valid,
    input  logic [RW-1:0]  issue_rs,
    input  logic [RW-1:0]  issue_rt,
    input  logic           issue_rs_used,
    input  logic           issue_rt_used,
    input  logic           issue_wr_en,
    input  logic [RW-1:0]  issue_wr_reg,
    input  logic [LW-1:0]  issue_lat,
    input  logic           flush,
    output logic           stall,
    output logic           issue_fire,
    output logic [AGW-1:0] fwd_rs,
    output logic [AGW-1:0] fwd_rt,
    output logic [15:0]    stall_cycles
);

    localparam logic [AGW-1:0] c_depth  = AGW'(DEPTH);
    localparam logic [LW-1:0]  c_maxLat = LW'(MAXLAT);

    logic [NREG-1:0] r_busy;
    logic [AGW-1:0]  r_age [NREG];
    logic [LW-1:0]   r_rem [NREG];
    logic [15:0]     r_stallCycles;

    logic            w_rsTracked;
    logic            w_rtTracked;
    logic            w_rsHazard;
    logic            w_rtHazard;
    logic [AGW-1:0]  w_rsFwd;
    logic [AGW-1:0]  w_rtFwd;
    logic [LW-1:0]   w_loadRem;
    logic            w_load;

    assign w_rsTracked = issue_rs_used && (issue_rs != '0) && r_busy[issue_rs];
    assign w_rtTracked = issue_rt_used && (issue_rt != '0) && r_busy[issue_rt];

`ifdef HAZARD_SB_FORWARD_EN
    assign w_rsHazard = w_rsTracked && (r_rem[issue_rs] != '0);
    assign w_rtHazard = w_rtTracked && (r_rem[issue_rt] != '0);
    // Write-back stage is served by the write-through register file.
    assign w_rsFwd = (w_rsTracked && (r_rem[issue_rs] == '0) && (r_age[issue_rs] < c_depth))
                   ? r_age[issue_rs] : '0;
    assign w_rtFwd = (w_rtTracked && (r_rem[issue_rt] == '0) && (r_age[issue_rt] < c_depth))
                   ? r_age[issue_rt] : '0;
`else
    assign w_rsHazard = w_rsTracked && (r_age[issue_rs] < c_depth);
    assign w_rtHazard = w_rtTracked && (r_age[issue_rt] < c_depth);
    assign w_rsFwd    = '0;
    assign w_rtFwd    = '0;
`endif

    assign stall        = issue_valid && (w_rsHazard || w_rtHazard);
    assign issue_fire   = issue_valid && !stall && !flush;
    assign fwd_rs       = w_rsFwd;
    assign fwd_rt       = w_rtFwd;
    assign stall_cycles = r_stallCycles;

    assign w_load = issue_fire && issue_wr_en && (issue_wr_reg != '0);

    // A latency of 0 behaves as 1; anything above MAXLAT is clamped.
    always_comb begin
        w_loadRem = '0;
        if (issue_lat == '0) begin
            w_loadRem = '0;
        end else if (issue_lat > c_maxLat) begin
            w_loadRem = c_maxLat - LW'(1);
        end else begin
            w_loadRem = issue_lat - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy        <= '0;
            r_stallCycles <= '0;
            for (int i = 0; i < NREG; i++) begin
                r_age[i] <= '0;
                r_rem[i] <= '0;
            end
        end else begin
            // Entry 0 is never loaded, so it stays idle from reset.
            for (int i = 1; i < NREG; i++) begin
                if (w_load && (issue_wr_reg == RW'(i))) begin
                    r_busy[i] <= 1'b1;
                    r_age[i]  <= AGW'(1);
                    r_rem[i]  <= w_loadRem;
                end else if (r_busy[i]) begin
                    if (r_age[i] == c_depth) begin
                        r_busy[i] <= 1'b0;
                        r_age[i]  <= '0;
                        r_rem[i]  <= '0;
                    end else begin
                        r_age[i] <= r_age[i] + AGW'(1);
                        if (r_rem[i] != '0) begin
                            r_rem[i] <= r_rem[i] - LW'(1);
                        end
                    end
                end
            end
            if (stall && (r_stallCycles != 16'hFFFF)) begin
                r_stallCycles <= r_stallCycles + 16'd1;
            end
        end
    end

endmodule

`default_nettype wire
